// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement-trace capture FIFO with show-ahead drain port, overflow
// drop counter, retirement-order gap detection and optional freeze-on-trap.
module ibex_rvfi_trace_buffer #(
  parameter int unsigned Depth        = 16,
  parameter bit          FreezeOnTrap = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rvfi_valid_i,
  input  logic [63:0]              rvfi_order_i,
  input  logic [31:0]              rvfi_pc_rdata_i,
  input  logic [31:0]              rvfi_insn_i,
  input  logic                     rvfi_trap_i,
  input  logic                     rvfi_intr_i,
  input  logic [4:0]               rvfi_rd_addr_i,
  input  logic [31:0]              rvfi_rd_wdata_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [102:0]             trace_data_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic [15:0]              dropped_o,
  output logic                     order_gap_o,
  output logic                     frozen_o
);

  localparam int unsigned PtrW      = $clog2(Depth);
  localparam logic [PtrW:0] LevelFull = (PtrW+1)'(Depth);

  logic [102:0]    mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW:0]   level;
  logic [15:0]     dropped;
  logic            order_gap;
  logic            frozen;
  logic [63:0]     last_order;
  logic            order_seen;

  logic            active;
  logic            capture;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic            track;
  logic [102:0]    record;

  // Reset and clear both discard any record arriving in the same cycle.
  assign active  = rst_ni & ~clear_i;
  assign full    = (level == LevelFull);
  assign pop     = trace_valid_o & trace_ready_i;
  assign capture = active & rvfi_valid_i & enable_i & ~frozen;
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;
  assign track   = active & rvfi_valid_i & enable_i;

  assign record = {rvfi_trap_i, rvfi_intr_i, rvfi_rd_addr_i, rvfi_pc_rdata_i,
                   rvfi_insn_i, rvfi_rd_wdata_i};

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= record;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      dropped <= '0;
      frozen  <= 1'b0;
    end else begin
      if (drop && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
      if (FreezeOnTrap && push && rvfi_trap_i) frozen <= 1'b1;
    end
  end

  // Order tracking sees frozen and dropped records too, so gaps are not hidden.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      order_gap  <= 1'b0;
      order_seen <= 1'b0;
      last_order <= '0;
    end else if (track) begin
      if (order_seen && rvfi_order_i != last_order + 64'd1) order_gap <= 1'b1;
      order_seen <= 1'b1;
      last_order <= rvfi_order_i;
    end
  end

  assign trace_valid_o = (level != '0);
  assign trace_data_o  = trace_valid_o ? mem[rd_ptr] : '0;
  assign level_o       = level;
  assign dropped_o     = dropped;
  assign order_gap_o   = order_gap;
  assign frozen_o      = frozen;

endmodule
